// File: rtl/decode_cycle.sv
// decode_cycle: RISC-V decode stage (control decode, imm extend, 32x32 regfile, ID/EX register); `DECODE_WB_BYPASS_EN adds write-through reads
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic        ResultSrcE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RD_E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E
);
  typedef struct packed {
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic        result_src;
    logic        branch;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } idex_t;
  logic [31:0] r_rf [32];
  idex_t       r_e, w_d, w_e;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2;
  logic        w_lw, w_sw, w_r, w_i, w_beq, w_byp1, w_byp2;
  logic [2:0]  w_alu_op, w_alu_ctrl;
  logic [31:0] w_imm, w_rd1, w_rd2;
  assign w_op  = InstrD[6:0];
  assign w_f3  = InstrD[14:12];
  assign w_rs1 = InstrD[19:15];
  assign w_rs2 = InstrD[24:20];
  assign w_lw  = w_op == 7'b0000011;
  assign w_sw  = w_op == 7'b0100011;
  assign w_r   = w_op == 7'b0110011;
  assign w_i   = w_op == 7'b0010011;
  assign w_beq = w_op == 7'b1100011;
  assign w_alu_op = w_f3 == 3'b000 ? ((w_r && InstrD[30]) ? 3'b001 : 3'b000) :
                    w_f3 == 3'b010 ? 3'b101 :
                    w_f3 == 3'b110 ? 3'b011 :
                    w_f3 == 3'b111 ? 3'b010 : 3'b000;
  assign w_alu_ctrl = w_beq ? 3'b001 : (w_r || w_i) ? w_alu_op : 3'b000;
  assign w_imm = (w_lw || w_i) ? {{20{InstrD[31]}}, InstrD[31:20]} :
                 w_sw          ? {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]} :
                 w_beq         ? {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0} : 32'd0;
`ifdef DECODE_WB_BYPASS_EN
  assign w_byp1 = RegWriteW && RDW != 5'd0 && RDW == w_rs1;
  assign w_byp2 = RegWriteW && RDW != 5'd0 && RDW == w_rs2;
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif
  assign w_rd1 = w_rs1 == 5'd0 ? 32'd0 : w_byp1 ? ResultW : r_rf[w_rs1];
  assign w_rd2 = w_rs2 == 5'd0 ? 32'd0 : w_byp2 ? ResultW : r_rf[w_rs2];
  assign w_d = {w_lw || w_r || w_i, w_lw || w_sw || w_i, w_sw, w_lw, w_beq, w_alu_ctrl,
                w_rd1, w_rd2, w_imm, PCD, PCPlus4D, InstrD[11:7], w_rs1, w_rs2};
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    else if (RegWriteW && RDW != 5'd0) r_rf[RDW] <= ResultW;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_e <= '0;
    else r_e <= w_d;
  assign w_e = rst ? r_e : '0;
  assign RegWriteE   = w_e.reg_write;
  assign ALUSrcE     = w_e.alu_src;
  assign MemWriteE   = w_e.mem_write;
  assign ResultSrcE  = w_e.result_src;
  assign BranchE     = w_e.branch;
  assign ALUControlE = w_e.alu_ctrl;
  assign RD1_E       = w_e.rd1;
  assign RD2_E       = w_e.rd2;
  assign Imm_Ext_E   = w_e.imm;
  assign PCE         = w_e.pc;
  assign PCPlus4E    = w_e.pc4;
  assign RD_E        = w_e.rd;
  assign RS1_E       = w_e.rs1;
  assign RS2_E       = w_e.rs2;
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed scoreboard bench for decode_cycle
module tb_decode_cycle;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_d = 32'h00A28313, pc_d = 32'd0, pc4_d = 32'd0, result_w = 32'd0;
  logic        reg_write_w = 1'b0;
  logic [4:0]  rd_w = 5'd0;
  logic        reg_write_e, alu_src_e, mem_write_e, result_src_e, branch_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
  logic [4:0]  rd_e, rs1_e, rs2_e;
  typedef struct packed {
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic        result_src;
    logic        branch;
    logic [2:0]  alu;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;
  exp_t        q[$];
  exp_t        obs;
  logic [31:0] m_rf [32];
  logic [31:0] pc = 32'h0000_1000;
  int          errors = 0, checks = 0;
  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(instr_d), .PCD(pc_d), .PCPlus4D(pc4_d),
    .RegWriteW(reg_write_w), .RDW(rd_w), .ResultW(result_w),
    .RegWriteE(reg_write_e), .ALUSrcE(alu_src_e), .MemWriteE(mem_write_e),
    .ResultSrcE(result_src_e), .BranchE(branch_e), .ALUControlE(alu_control_e),
    .RD1_E(rd1_e), .RD2_E(rd2_e), .Imm_Ext_E(imm_e), .PCE(pc_e), .PCPlus4E(pc4_e),
    .RD_E(rd_e), .RS1_E(rs1_e), .RS2_E(rs2_e)
  );
  always #5 clk = ~clk;
  assign obs = {reg_write_e, alu_src_e, mem_write_e, result_src_e, branch_e, alu_control_e,
                rd1_e, rd2_e, imm_e, pc_e, pc4_e, rd_e, rs1_e, rs2_e};
  function automatic logic [31:0] rdp(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (reg_write_w && rd_w == rs) return result_w;
`endif
    return m_rf[rs];
  endfunction
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
    exp_t e = '0;
    logic [2:0] op3;
    case (ins[14:12])
      3'b000:  op3 = (ins[6:0] == 7'b0110011 && ins[30]) ? 3'b001 : 3'b000;
      3'b010:  op3 = 3'b101;
      3'b110:  op3 = 3'b011;
      3'b111:  op3 = 3'b010;
      default: op3 = 3'b000;
    endcase
    e.pc = p; e.pc4 = p + 32'd4;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.rd1 = rdp(ins[19:15]); e.rd2 = rdp(ins[24:20]);
    case (ins[6:0])
      7'b0000011: begin {e.reg_write, e.alu_src, e.result_src} = 3'b111; e.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0100011: begin {e.alu_src, e.mem_write} = 2'b11; e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'b0110011: begin e.reg_write = 1'b1; e.alu = op3; end
      7'b0010011: begin {e.reg_write, e.alu_src} = 2'b11; e.alu = op3; e.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b1100011: begin e.branch = 1'b1; e.alu = 3'b001; e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
      default: ;
    endcase
    return e;
  endfunction
  task automatic chk(input string tag, input logic [182:0] o, input logic [182:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic drive(input logic [31:0] ins, input logic rw, input logic [4:0] rdw, input logic [31:0] res);
    instr_d = ins; pc_d = pc; pc4_d = pc + 32'd4;
    reg_write_w = rw; rd_w = rdw; result_w = res;
    q.push_back(model(ins, pc));
    pc = pc + 32'd4;
  endtask
  task automatic capture(input string tag);
    @(posedge clk);
    if (reg_write_w && rd_w != 5'd0) m_rf[rd_w] = result_w;
    #1;
    if (q.size() == 0) chk({tag, "_sb_empty"}, 183'd1, 183'd0);
    else chk(tag, obs, q.pop_front());
  endtask
  task automatic step(input string tag, input logic [31:0] ins, input logic rw, input logic [4:0] rdw, input logic [31:0] res);
    @(negedge clk);
    drive(ins, rw, rdw, res);
    capture(tag);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    pc_d = 32'h10; pc4_d = 32'h14; reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'h55;
    repeat (2) begin
      @(posedge clk);
      #1 chk("reset_hold", obs, '0);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(32'h0002_8313, 1'b0, 5'd0, 32'd0);
    capture("after_reset");
    chk("x5_after_reset", rd1_e, 32'd0);
    step("write_x5", 32'h0000_0013, 1'b1, 5'd5, 32'h0000_00AA);
    step("addi", 32'h00A2_8313, 1'b0, 5'd0, 32'd0);
    chk("addi_rd1", rd1_e, 32'hAA);
    chk("addi_imm", imm_e, 32'h0000_000A);
    chk("addi_ctrl", {alu_src_e, reg_write_e, alu_control_e, rd_e}, {1'b1, 1'b1, 3'b000, 5'd6});
    step("beq", 32'hFE00_08E3, 1'b0, 5'd0, 32'd0);
    chk("beq_ctrl", {branch_e, alu_control_e, reg_write_e}, {1'b1, 3'b001, 1'b0});
    chk("beq_imm", imm_e, 32'hFFFF_FFF0);
    step("write_x0", 32'h0000_0033, 1'b1, 5'd0, 32'hDEAD_BEEF);
    chk("write_x0_rd1", rd1_e, 32'd0);
    step("read_x0", 32'h0000_0033, 1'b0, 5'd0, 32'd0);
    chk("read_x0_rd1", rd1_e, 32'd0);
    step("write_x7", 32'h0000_0013, 1'b1, 5'd7, 32'h0000_1111);
    step("bypass_x7", 32'h0003_80B3, 1'b1, 5'd7, 32'h0000_1234);
`ifdef DECODE_WB_BYPASS_EN
    chk("bypass_rd1", rd1_e, 32'h1234);
`else
    chk("bypass_rd1", rd1_e, 32'h1111);
`endif
    step("after_x7", 32'h0003_80B3, 1'b1, 5'd1, 32'h8000_0005);
    chk("x7_visible", rd1_e, 32'h1234);
    step("write_x2", 32'h0000_0013, 1'b1, 5'd2, 32'h0000_0007);
    step("sub", 32'h4020_81B3, 1'b0, 5'd0, 32'd0);
    step("and", 32'h0020_F1B3, 1'b0, 5'd0, 32'd0);
    step("or", 32'h0020_E1B3, 1'b1, 5'd2, 32'hFFFF_0000);
    step("slt", 32'h0020_A1B3, 1'b0, 5'd0, 32'd0);
    step("sll_as_add", 32'h0020_91B3, 1'b0, 5'd0, 32'd0);
    step("slti_neg", 32'hFFF0_A193, 1'b0, 5'd0, 32'd0);
    step("addi_bit30", 32'h4000_8193, 1'b0, 5'd0, 32'd0);
    chk("addi_bit30_alu", alu_control_e, 3'b000);
    step("lw", 32'hFFC0_A203, 1'b0, 5'd0, 32'd0);
    step("sw", 32'h0020_A423, 1'b0, 5'd0, 32'd0);
    step("unknown_op", 32'hFFFF_F0EF, 1'b0, 5'd0, 32'd0);
    chk("unknown_ctrl", {reg_write_e, alu_src_e, mem_write_e, result_src_e, branch_e, alu_control_e, imm_e}, '0);
    @(negedge clk);
    drive(32'h0020_8133, 1'b1, 5'd9, 32'h99);
    #2 rst = 1'b0;
    q.delete();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    #1 chk("midop_reset_async", obs, '0);
    @(posedge clk);
    #1 chk("midop_reset_hold", obs, '0);
    @(negedge clk);
    rst = 1'b1;
    drive(32'h0002_8313, 1'b0, 5'd0, 32'd0);
    capture("first_after_midop");
    chk("x5_cleared", rd1_e, 32'd0);
    step("x9_cleared", 32'h0004_8313, 1'b0, 5'd0, 32'd0);
    chk("x9_rd1", rd1_e, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
